// File: rtl/mcalu_rs_pkg.sv
// Shared definitions for the mcalu reservation station: tag width default,
// opcode encodings and the entry record layout.
package mcalu_rs_pkg;

    localparam int TAGW_DEF = 7;

    // bit4 marks multi-cycle ops, bit2 (with bit4) marks div/rem
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b01000;
    localparam logic [4:0] OP_SLT  = 5'b01001;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_MULH = 5'b10001;
    localparam logic [4:0] OP_DIV  = 5'b10100;
    localparam logic [4:0] OP_DIVU = 5'b10101;
    localparam logic [4:0] OP_REM  = 5'b10110;
    localparam logic [4:0] OP_REMU = 5'b10111;

    typedef struct packed {
        logic                valid;
        logic [4:0]          op;
        logic [TAGW_DEF-1:0] robid;
        logic [5:0]          rd;
        logic                op1_rdy;
        logic [TAGW_DEF-1:0] op1_tag;
        logic [31:0]         op1_val;
        logic                op2_rdy;
        logic [TAGW_DEF-1:0] op2_tag;
        logic [31:0]         op2_val;
    } rs_entry_t;

    function automatic logic op_is_multi(input logic [4:0] op);
        return op[4];
    endfunction

    function automatic logic op_is_divrem(input logic [4:0] op);
        return op[4] & op[2];
    endfunction

endpackage

// File: rtl/mcalu_rs_wakeup.sv
// One source operand of one RS slot: selects new contents (dispatch or shift)
// and captures a matching result broadcast on the way into the register.
module rs_entry_wakeup
    import mcalu_rs_pkg::*;
#(
    parameter int TAGW = TAGW_DEF
) (
    input  logic            clk,
    input  logic            load,
    input  logic            src_rdy,
    input  logic [TAGW-1:0] src_tag,
    input  logic [31:0]     src_val,
    input  logic            wb_valid,
    input  logic [TAGW-1:0] wb_robid,
    input  logic [31:0]     wb_result,
    output logic            rdy,
    output logic [TAGW-1:0] tag,
    output logic [31:0]     val
);

    logic            n_rdy;
    logic [TAGW-1:0] n_tag;
    logic [31:0]     n_val;
    logic            hit;

    // the same compare serves held, shifting and freshly dispatched operands
    always_comb begin
        n_rdy = load ? src_rdy : rdy;
        n_tag = load ? src_tag : tag;
        n_val = load ? src_val : val;
        hit   = ~n_rdy & wb_valid & (n_tag == wb_robid);
    end

    always_ff @(posedge clk) begin
        rdy <= n_rdy | hit;
        tag <= n_tag;
        val <= hit ? wb_result : n_val;
    end

endmodule

// File: rtl/mcalu_rs.sv
// Age-ordered collapsing reservation station feeding the mcalu pipe.
// Slot 0 is oldest; issue picks the oldest ready slot and shifts younger ones down.
module mcalu_rs
    import mcalu_rs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAGW  = TAGW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            disp_valid,
    input  logic [4:0]      disp_op,
    input  logic [TAGW-1:0] disp_robid,
    input  logic [5:0]      disp_rd,
    input  logic            disp_op1_rdy,
    input  logic [TAGW-1:0] disp_op1_tag,
    input  logic [31:0]     disp_op1_val,
    input  logic            disp_op2_rdy,
    input  logic [TAGW-1:0] disp_op2_tag,
    input  logic [31:0]     disp_op2_val,
    output logic            rs_full,
    input  logic            wb_valid,
    input  logic [TAGW-1:0] wb_robid,
    input  logic [31:0]     wb_result,
    output logic            exers_mcalu_issue,
    output logic [4:0]      exers_mcalu_op,
    output logic [TAGW-1:0] exers_robid,
    output logic [5:0]      exers_rd,
    output logic [31:0]     exers_op1,
    output logic [31:0]     exers_op2,
    input  logic            mcalu_stall,
    input  logic            rob_flush
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]           valid_q;
    logic [DEPTH-1:0][4:0]      op_q;
    logic [DEPTH-1:0][TAGW-1:0] robid_q;
    logic [DEPTH-1:0][5:0]      rd_q;
    logic [DEPTH-1:0]           r1, r2;
    logic [DEPTH-1:0][TAGW-1:0] t1, t2;
    logic [DEPTH-1:0][31:0]     v1, v2;

    logic [CW-1:0]    count_q, count_col;
    logic [DEPTH-1:0] ready, shift, load;
    logic [IW-1:0]    sel;
    logic             any_rdy, issue, disp_acc;

    assign ready = valid_q & r1 & r2;

    always_comb begin
        sel     = '0;
        any_rdy = |ready;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (ready[i]) sel = IW'(i);
    end

    assign issue     = any_rdy & ~mcalu_stall & ~rob_flush;
    assign rs_full   = (count_q == CW'(DEPTH));
    assign disp_acc  = disp_valid & ~rs_full & ~rob_flush;
    // dispatch lands behind the survivors of this cycle's collapse
    assign count_col = count_q - CW'(issue);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         count_q <= '0;
        else if (rob_flush) count_q <= '0;
        else                count_q <= count_col + CW'(disp_acc);
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        localparam int UP = (i < DEPTH - 1) ? i + 1 : i;

        assign shift[i] = issue && (i >= int'(sel));
        assign load[i]  = disp_acc && (int'(count_col) == i);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)         valid_q[i] <= 1'b0;
            else if (rob_flush) valid_q[i] <= 1'b0;
            else if (load[i])   valid_q[i] <= 1'b1;
            else if (shift[i])  valid_q[i] <= (i < DEPTH - 1) ? valid_q[UP] : 1'b0;
        end

        always_ff @(posedge clk) begin
            if (load[i]) begin
                op_q[i]    <= disp_op;
                robid_q[i] <= disp_robid;
                rd_q[i]    <= disp_rd;
            end else if (shift[i]) begin
                op_q[i]    <= op_q[UP];
                robid_q[i] <= robid_q[UP];
                rd_q[i]    <= rd_q[UP];
            end
        end

        rs_entry_wakeup #(.TAGW(TAGW)) u_op1 (
            .clk      (clk),
            .load     (load[i] | shift[i]),
            .src_rdy  (load[i] ? disp_op1_rdy : r1[UP]),
            .src_tag  (load[i] ? disp_op1_tag : t1[UP]),
            .src_val  (load[i] ? disp_op1_val : v1[UP]),
            .wb_valid (wb_valid),
            .wb_robid (wb_robid),
            .wb_result(wb_result),
            .rdy      (r1[i]),
            .tag      (t1[i]),
            .val      (v1[i])
        );

        rs_entry_wakeup #(.TAGW(TAGW)) u_op2 (
            .clk      (clk),
            .load     (load[i] | shift[i]),
            .src_rdy  (load[i] ? disp_op2_rdy : r2[UP]),
            .src_tag  (load[i] ? disp_op2_tag : t2[UP]),
            .src_val  (load[i] ? disp_op2_val : v2[UP]),
            .wb_valid (wb_valid),
            .wb_robid (wb_robid),
            .wb_result(wb_result),
            .rdy      (r2[i]),
            .tag      (t2[i]),
            .val      (v2[i])
        );
    end

    assign exers_mcalu_issue = issue;
    assign exers_mcalu_op    = op_q[sel];
    assign exers_robid       = robid_q[sel];
    assign exers_rd          = rd_q[sel];
    assign exers_op1         = v1[sel];
    assign exers_op2         = v2[sel];

endmodule

// File: tb/tb_mcalu_rs.sv
// Bench for mcalu_rs: table of single-entry cases plus ordering, stall,
// flush and async-reset sequences; issues are checked cycle-exactly.
module tb_mcalu_rs;
    import mcalu_rs_pkg::*;

    logic        clk, rst_n;
    logic        disp_valid, disp_op1_rdy, disp_op2_rdy;
    logic [4:0]  disp_op;
    logic [6:0]  disp_robid, disp_op1_tag, disp_op2_tag;
    logic [5:0]  disp_rd;
    logic [31:0] disp_op1_val, disp_op2_val;
    logic        rs_full;
    logic        wb_valid;
    logic [6:0]  wb_robid;
    logic [31:0] wb_result;
    logic        exers_mcalu_issue;
    logic [4:0]  exers_mcalu_op;
    logic [6:0]  exers_robid;
    logic [5:0]  exers_rd;
    logic [31:0] exers_op1, exers_op2;
    logic        mcalu_stall, rob_flush;

    mcalu_rs dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_robid(disp_robid), .disp_rd(disp_rd),
        .disp_op1_rdy(disp_op1_rdy), .disp_op1_tag(disp_op1_tag), .disp_op1_val(disp_op1_val),
        .disp_op2_rdy(disp_op2_rdy), .disp_op2_tag(disp_op2_tag), .disp_op2_val(disp_op2_val),
        .rs_full(rs_full),
        .wb_valid(wb_valid), .wb_robid(wb_robid), .wb_result(wb_result),
        .exers_mcalu_issue(exers_mcalu_issue), .exers_mcalu_op(exers_mcalu_op),
        .exers_robid(exers_robid), .exers_rd(exers_rd),
        .exers_op1(exers_op1), .exers_op2(exers_op2),
        .mcalu_stall(mcalu_stall), .rob_flush(rob_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    rs_entry_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // every cycle: an issue must match the entry expected for this cycle, and
    // an expected entry must issue in exactly this cycle
    always @(negedge clk) begin
        #4;
        if (exers_mcalu_issue === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_issue", 32'(exers_robid), 32'h7f_ffff);
            else begin
                rs_entry_t e;
                e = exp_q.pop_front();
                chk("issue_op",    32'(exers_mcalu_op), 32'(e.op));
                chk("issue_robid", 32'(exers_robid),    32'(e.robid));
                chk("issue_rd",    32'(exers_rd),       32'(e.rd));
                chk("issue_op1",   exers_op1,           e.op1_val);
                chk("issue_op2",   exers_op2,           e.op2_val);
            end
        end else if (exp_q.size() != 0) begin
            rs_entry_t e;
            e = exp_q.pop_front();
            chk("missed_issue", 32'(exers_mcalu_issue), 32'(e.robid) | 32'h100);
        end
    end

    task automatic next();
        @(negedge clk);
        disp_valid = 1'b0;
        wb_valid   = 1'b0;
        rob_flush  = 1'b0;
    endtask

    task automatic disp(input logic [4:0] op, input logic [6:0] rob, input logic [5:0] rd,
                        input logic r1, input logic [6:0] t1, input logic [31:0] v1,
                        input logic r2, input logic [6:0] t2, input logic [31:0] v2);
        disp_valid = 1'b1; disp_op = op; disp_robid = rob; disp_rd = rd;
        disp_op1_rdy = r1; disp_op1_tag = t1; disp_op1_val = v1;
        disp_op2_rdy = r2; disp_op2_tag = t2; disp_op2_val = v2;
    endtask

    task automatic wb(input logic [6:0] t, input logic [31:0] r);
        wb_valid = 1'b1; wb_robid = t; wb_result = r;
    endtask

    task automatic exp_iss(input logic [4:0] op, input logic [6:0] rob, input logic [5:0] rd,
                           input logic [31:0] o1, input logic [31:0] o2);
        rs_entry_t e;
        e = '0;
        e.op = op; e.robid = rob; e.rd = rd; e.op1_val = o1; e.op2_val = o2;
        exp_q.push_back(e);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [6:0]  rob;
        logic [5:0]  rd;
        logic        r1;
        logic [6:0]  t1;
        logic [31:0] v1;
        logic        r2;
        logic [6:0]  t2;
        logic [31:0] v2;
        logic        wbv;
        logic [6:0]  wbt;
        logic [31:0] wbr;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;
    vec_t tv[6];

    initial begin
        tv[0] = '{OP_ADD, 7'd1,   6'd3,  1, 7'd0,  32'd3,        1, 7'd0,  32'd4,        0, 7'd0,   32'd0,      32'd3,        32'd4};
        tv[1] = '{OP_SUB, 7'd2,   6'd4,  1, 7'd0,  32'hA,        0, 7'd9,  32'd0,        1, 7'd9,   32'hDEAD,   32'hA,        32'hDEAD};
        tv[2] = '{OP_AND, 7'd3,   6'd5,  0, 7'd5,  32'd0,        1, 7'd0,  32'd7,        1, 7'd5,   32'h1234,   32'h1234,     32'd7};
        tv[3] = '{OP_MUL, 7'd4,   6'd6,  0, 7'd20, 32'd0,        0, 7'd20, 32'd0,        1, 7'd20,  32'hAB,     32'hAB,       32'hAB};
        tv[4] = '{OP_XOR, 7'd5,   6'd7,  1, 7'd9,  32'h11,       1, 7'd0,  32'h22,       1, 7'd9,   32'h99,     32'h11,       32'h22};
        tv[5] = '{OP_DIV, 7'd127, 6'd63, 1, 7'd0,  32'hFFFFFFFF, 1, 7'd0,  32'h80000000, 1, 7'd127, 32'h0,      32'hFFFFFFFF, 32'h80000000};

        rst_n = 1'b1; mcalu_stall = 1'b0; rob_flush = 1'b0;
        disp_valid = 1'b0; disp_op = '0; disp_robid = '0; disp_rd = '0;
        disp_op1_rdy = 1'b0; disp_op1_tag = '0; disp_op1_val = '0;
        disp_op2_rdy = 1'b0; disp_op2_tag = '0; disp_op2_val = '0;
        wb_valid = 1'b0; wb_robid = '0; wb_result = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_full",  32'(rs_full), 0);
        chk("reset_issue", 32'(exers_mcalu_issue), 0);
        next(); next();
        rst_n = 1'b1;
        next();
        chk("post_reset_full", 32'(rs_full), 0);

        // single-entry table: dispatch (with optional same-cycle broadcast), issue next cycle
        for (int k = 0; k < 6; k++) begin
            next();
            disp(tv[k].op, tv[k].rob, tv[k].rd, tv[k].r1, tv[k].t1, tv[k].v1,
                 tv[k].r2, tv[k].t2, tv[k].v2);
            if (tv[k].wbv) wb(tv[k].wbt, tv[k].wbr);
            next();
            exp_iss(tv[k].op, tv[k].rob, tv[k].rd, tv[k].e1, tv[k].e2);
            next();
        end

        // younger ready entry overtakes a waiting one; wakeup issues a cycle later
        next(); disp(OP_ADD, 7'd10, 6'd1, 0, 7'd12, 32'd0, 1, 7'd0, 32'd1);
        next(); disp(OP_SUB, 7'd11, 6'd2, 1, 7'd0, 32'd5, 1, 7'd0, 32'd6);
        next(); exp_iss(OP_SUB, 7'd11, 6'd2, 32'd5, 32'd6);
        next(); wb(7'd12, 32'h55);
        next(); exp_iss(OP_ADD, 7'd10, 6'd1, 32'h55, 32'd1);
        next();

        // fill under stall, drop overflow, drain in age order
        mcalu_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next();
            #1;
            if (k == 3) chk("full_at_3", 32'(rs_full), 0);
            disp(OP_MUL, 7'(20 + k), 6'(k), 1, 7'd0, 32'h100 + 32'(k), 1, 7'd0, 32'h200 + 32'(k));
        end
        next(); #1 chk("full_at_4", 32'(rs_full), 1);
        disp(OP_MUL, 7'd24, 6'd9, 1, 7'd0, 32'hBAD, 1, 7'd0, 32'hBAD);
        next(); #1 chk("full_after_drop", 32'(rs_full), 1);
        mcalu_stall = 1'b0;
        disp(OP_MUL, 7'd25, 6'd9, 1, 7'd0, 32'hBAD, 1, 7'd0, 32'hBAD);
        exp_iss(OP_MUL, 7'd20, 6'd0, 32'h100, 32'h200);
        for (int k = 1; k < 4; k++) begin
            next();
            #1;
            if (k == 1) chk("full_after_issue", 32'(rs_full), 0);
            exp_iss(OP_MUL, 7'(20 + k), 6'(k), 32'h100 + 32'(k), 32'h200 + 32'(k));
        end
        next(); next();

        // dispatch, wakeup of a shifting entry and issue in one cycle
        mcalu_stall = 1'b1;
        next(); disp(OP_OR,  7'd40, 6'd1, 1, 7'd0,  32'd1, 1, 7'd0, 32'd2);
        next(); disp(OP_AND, 7'd41, 6'd2, 0, 7'd50, 32'd0, 1, 7'd0, 32'd3);
        next(); mcalu_stall = 1'b0;
        disp(OP_XOR, 7'd42, 6'd3, 1, 7'd0, 32'd4, 1, 7'd0, 32'd5);
        wb(7'd50, 32'h77);
        exp_iss(OP_OR, 7'd40, 6'd1, 32'd1, 32'd2);
        next(); exp_iss(OP_AND, 7'd41, 6'd2, 32'h77, 32'd3);
        next(); exp_iss(OP_XOR, 7'd42, 6'd3, 32'd4, 32'd5);
        next();

        // flush with three held entries and a same-cycle dispatch
        mcalu_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next(); disp(OP_ADD, 7'(30 + k), 6'd0, 1, 7'd0, 32'd1, 1, 7'd0, 32'd1);
        end
        next(); mcalu_stall = 1'b0; rob_flush = 1'b1;
        disp(OP_ADD, 7'd33, 6'd0, 1, 7'd0, 32'd1, 1, 7'd0, 32'd1);
        #1 chk("flush_issue", 32'(exers_mcalu_issue), 0);
        next(); #1 chk("flush_full", 32'(rs_full), 0);
        next(); next();
        disp(OP_SLT, 7'd34, 6'd8, 1, 7'd0, 32'hC, 1, 7'd0, 32'hD);
        next(); exp_iss(OP_SLT, 7'd34, 6'd8, 32'hC, 32'hD);
        next();

        // asynchronous reset between edges with two entries held
        mcalu_stall = 1'b1;
        next(); disp(OP_ADD, 7'd60, 6'd0, 1, 7'd0, 32'd1, 1, 7'd0, 32'd1);
        next(); disp(OP_ADD, 7'd61, 6'd0, 1, 7'd0, 32'd1, 1, 7'd0, 32'd1);
        next();
        #1 mcalu_stall = 1'b0; rst_n = 1'b0;
        #1 chk("async_rst_issue", 32'(exers_mcalu_issue), 0);
        chk("async_rst_full", 32'(rs_full), 0);
        next(); next();
        rst_n = 1'b1;
        next(); next();
        disp(OP_REM, 7'd62, 6'd5, 1, 7'd0, 32'd9, 1, 7'd0, 32'd4);
        next(); exp_iss(OP_REM, 7'd62, 6'd5, 32'd9, 32'd4);
        next(); next();

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
